// File: rtl/pipeline_pkg.sv
// pipeline_pkg: constants and types shared by the pipeline hazard logic.
//   hz_state_e : hazard controller FSM encoding (RUN / STALL / FLUSH)
//   REG_ZERO   : architectural $zero register index (never a hazard source)
//   NOP_INSTR  : instruction word IF/ID loads when flushed
package pipeline_pkg;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_STALL = 2'd1,
        HZ_FLUSH = 2'd2
    } hz_state_e;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/sat_counter16.sv
// sat_counter16: 16-bit up-counter that sticks at 16'hFFFF.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low clear
//   inc_i   : count this cycle
//   count_o : current count
module sat_counter16 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall and taken-branch flush control for a 5-stage pipeline.
// Outputs are combinational from the FSM state and current inputs, so a hazard is
// acted on in the cycle it appears; the FSM only extends multi-cycle stalls/flushes.
// Ports:
//   Clk, Reset_n               : clock (rising edge), async active-low reset
//   IFID_rs/rt, IFID_UsesRt    : source fields of the instruction in IF/ID
//   IDEX_MemRead, IDEX_rt      : load in ID/EX and its destination register
//   BranchTaken                : branch resolved taken (from EX/MEM)
//   PCWrite, IFIDWrite         : 1 = PC / IF/ID may update
//   IFID_Flush, IDEX_Bubble    : 1 = squash IF/ID / zero ID/EX control
//   Busy                       : FSM is in STALL or FLUSH
//   StallCycles, FlushCycles   : saturating perf counters (only with HAZARD_PERF_CNT_EN)
// Build option: define HAZARD_PERF_CNT_EN to add the performance counters.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES   = 1,
    parameter int unsigned BRANCH_FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W               = 3
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [4:0]  IFID_rs,
    input  logic [4:0]  IFID_rt,
    input  logic        IFID_UsesRt,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_rt,
    input  logic        BranchTaken,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFID_Flush,
    output logic        IDEX_Bubble,
    output logic        Busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0] StallCycles,
    output logic [15:0] FlushCycles
`endif
);

    localparam logic [CNT_W-1:0] StallReload = CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] FlushReload = CNT_W'(BRANCH_FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble;

    assign load_use = IDEX_MemRead && (IDEX_rt != REG_ZERO) &&
                      ((IDEX_rt == IFID_rs) || (IFID_UsesRt && (IDEX_rt == IFID_rt)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;

        case (state_q)
            HZ_RUN, HZ_STALL, HZ_FLUSH: begin
                if (BranchTaken) begin
                    // A taken branch wins in every state: any stalled or in-flight
                    // younger instruction is squashed, so loadUse is moot.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (BRANCH_FLUSH_CYCLES > 1) begin
                        state_d = HZ_FLUSH;
                        cnt_d   = FlushReload;
                    end else begin
                        state_d = HZ_RUN;
                        cnt_d   = '0;
                    end
                end else if (state_q == HZ_STALL) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    if (cnt_q <= CntOne) begin
                        state_d = HZ_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end else if (state_q == HZ_FLUSH) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (cnt_q <= CntOne) begin
                        state_d = HZ_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = HZ_STALL;
                        cnt_d   = StallReload;
                    end
                end
            end
            default: begin
                state_d = HZ_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset forces a frozen, fully squashed pipeline regardless of inputs.
    assign PCWrite     = Reset_n & pc_write;
    assign IFIDWrite   = Reset_n & ifid_write;
    assign IFID_Flush  = ~Reset_n | ifid_flush;
    assign IDEX_Bubble = ~Reset_n | idex_bubble;
    assign Busy        = Reset_n & (state_q != HZ_RUN);

`ifdef HAZARD_PERF_CNT_EN
    sat_counter16 u_stall_cnt (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .inc_i   (~PCWrite),
        .count_o (StallCycles)
    );

    sat_counter16 u_flush_cnt (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .inc_i   (IFID_Flush),
        .count_o (FlushCycles)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
// dut_a uses the default depths (stall 1, flush 2); dut_b uses stall 3, flush 2.
// Output vectors are packed as {PCWrite, IFIDWrite, IFID_Flush, IDEX_Bubble, Busy}.
module tb_hazard_ctrl;

    localparam logic [4:0] OIdle  = 5'b11000;
    localparam logic [4:0] OStall = 5'b00010;
    localparam logic [4:0] OStBsy = 5'b00011;
    localparam logic [4:0] OBrRun = 5'b11110;
    localparam logic [4:0] OFlush = 5'b11111;
    localparam logic [4:0] ORst   = 5'b00110;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] ifid_rs, ifid_rt, idex_rt;
    logic       ifid_uses_rt, idex_mem_read, branch_taken;

    logic a_pcw, a_ifw, a_fl, a_bub, a_busy;
    logic b_pcw, b_ifw, b_fl, b_bub, b_busy;
    logic [4:0] a_out, b_out;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign a_out = {a_pcw, a_ifw, a_fl, a_bub, a_busy};
    assign b_out = {b_pcw, b_ifw, b_fl, b_bub, b_busy};

    hazard_ctrl dut_a (
        .Clk          (clk),
        .Reset_n      (rst_n),
        .IFID_rs      (ifid_rs),
        .IFID_rt      (ifid_rt),
        .IFID_UsesRt  (ifid_uses_rt),
        .IDEX_MemRead (idex_mem_read),
        .IDEX_rt      (idex_rt),
        .BranchTaken  (branch_taken),
        .PCWrite      (a_pcw),
        .IFIDWrite    (a_ifw),
        .IFID_Flush   (a_fl),
        .IDEX_Bubble  (a_bub),
        .Busy         (a_busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .StallCycles  (a_stall_cnt),
        .FlushCycles  (a_flush_cnt)
`endif
    );

    hazard_ctrl #(
        .LOAD_STALL_CYCLES   (3),
        .BRANCH_FLUSH_CYCLES (2)
    ) dut_b (
        .Clk          (clk),
        .Reset_n      (rst_n),
        .IFID_rs      (ifid_rs),
        .IFID_rt      (ifid_rt),
        .IFID_UsesRt  (ifid_uses_rt),
        .IDEX_MemRead (idex_mem_read),
        .IDEX_rt      (idex_rt),
        .BranchTaken  (branch_taken),
        .PCWrite      (b_pcw),
        .IFIDWrite    (b_ifw),
        .IFID_Flush   (b_fl),
        .IDEX_Bubble  (b_bub),
        .Busy         (b_busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .StallCycles  (b_stall_cnt),
        .FlushCycles  (b_flush_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic mrd, input logic [4:0] xrt, input logic br);
        ifid_rs       = rs;
        ifid_rt       = rt;
        ifid_uses_rt  = uses;
        idex_mem_read = mrd;
        idex_rt       = xrt;
        branch_taken  = br;
    endtask

    // Apply one cycle of inputs, check mid-cycle, then advance past the next rising edge.
    task automatic vec(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses, input logic mrd, input logic [4:0] xrt,
                       input logic br, input logic [4:0] exp_a, input logic [4:0] exp_b,
                       input logic chk_b);
        drive(rs, rt, uses, mrd, xrt, br);
        #4;
        check_eq({tag, "_a"}, {11'd0, a_out}, {11'd0, exp_a});
        if (chk_b) check_eq({tag, "_b"}, {11'd0, b_out}, {11'd0, exp_b});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(5'($urandom), 5'($urandom), 1'b1, 1'b1, 5'($urandom), 1'b1);
        #3;
        check_eq("rst_a", {11'd0, a_out}, {11'd0, ORst});
        check_eq("rst_b", {11'd0, b_out}, {11'd0, ORst});
        @(posedge clk);
        #1;
        drive(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 1'b0);
        #1;
        check_eq("rst_rand_a", {11'd0, a_out}, {11'd0, ORst});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vec("rel",     0, 0, 0, 0, 0, 0, OIdle,  OIdle,  1'b1);

        // Load-use on rs: 1-cycle stall in dut_a, 3-cycle stall in dut_b
        vec("lu_rs",   8, 0, 0, 1, 8, 0, OStall, OStall, 1'b1);
        vec("lu_c2",   0, 0, 0, 0, 0, 0, OIdle,  OStBsy, 1'b1);
        vec("lu_c3",   0, 0, 0, 0, 0, 0, OIdle,  OStBsy, 1'b1);
        vec("lu_end",  0, 0, 0, 0, 0, 0, OIdle,  OIdle,  1'b1);

        // $zero never hazards; rt only matters when the consumer reads it
        vec("zero",    0, 0, 0, 1, 0, 0, OIdle,  OIdle,  1'b1);
        vec("rt_gate", 1, 9, 0, 1, 9, 0, OIdle,  OIdle,  1'b1);
        vec("rt_use",  1, 9, 1, 1, 9, 0, OStall, OStall, 1'b1);
        vec("rt_c2",   0, 0, 0, 0, 0, 0, OIdle,  OStBsy, 1'b1);
        vec("rt_c3",   0, 0, 0, 0, 0, 0, OIdle,  OStBsy, 1'b1);
        vec("rt_end",  0, 0, 0, 0, 0, 0, OIdle,  OIdle,  1'b1);

        // Taken branch: two squash cycles
        vec("br",      0, 0, 0, 0, 0, 1, OBrRun, OBrRun, 1'b1);
        vec("br_c2",   0, 0, 0, 0, 0, 0, OFlush, OFlush, 1'b1);
        vec("br_end",  0, 0, 0, 0, 0, 0, OIdle,  OIdle,  1'b1);

        // Branch beats load-use in the same cycle
        vec("both",    8, 0, 0, 1, 8, 1, OBrRun, OBrRun, 1'b1);
        vec("both_c2", 0, 0, 0, 0, 0, 0, OFlush, OFlush, 1'b1);
        vec("both_e",  0, 0, 0, 0, 0, 0, OIdle,  OIdle,  1'b1);

        // Branch in second cycle of dut_b's 3-cycle stall aborts it
        vec("ab_lu",   8, 0, 0, 1, 8, 0, OStall, OStall, 1'b1);
        vec("ab_br",   0, 0, 0, 0, 0, 1, OBrRun, OFlush, 1'b1);
        vec("ab_c3",   0, 0, 0, 0, 0, 0, OFlush, OFlush, 1'b1);
        vec("ab_end",  0, 0, 0, 0, 0, 0, OIdle,  OIdle,  1'b1);

        // Branch in FLUSH reloads; loadUse in FLUSH is ignored
        vec("rl_br",   0, 0, 0, 0, 0, 1, OBrRun, OBrRun, 1'b1);
        vec("rl_br2",  0, 0, 0, 0, 0, 1, OFlush, OFlush, 1'b1);
        vec("rl_lu",   8, 0, 0, 1, 8, 0, OFlush, OFlush, 1'b1);
        vec("rl_end",  0, 0, 0, 0, 0, 0, OIdle,  OIdle,  1'b1);

        // Reset asserted mid-FLUSH takes effect immediately
        vec("mf_br",   0, 0, 0, 0, 0, 1, OBrRun, OBrRun, 1'b1);
        drive(0, 0, 0, 0, 0, 0);
        #4;
        check_eq("mf_in_a", {11'd0, a_out}, {11'd0, OFlush});
        rst_n = 1'b0;
        #1;
        check_eq("mf_rst_a", {11'd0, a_out}, {11'd0, ORst});
        check_eq("mf_rst_b", {11'd0, b_out}, {11'd0, ORst});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vec("mf_post", 0, 0, 0, 0, 0, 0, OIdle,  OIdle,  1'b1);

`ifdef HAZARD_PERF_CNT_EN
        rst_n = 1'b0;
        #1;
        check_eq("pc_clr_s", a_stall_cnt, 16'd0);
        check_eq("pc_clr_f", a_flush_cnt, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vec("pc_lu",   8, 0, 0, 1, 8, 0, OStall, OStall, 1'b0);
            vec("pc_idle", 0, 0, 0, 0, 0, 0, OIdle,  OIdle,  1'b0);
        end
        vec("pc_br",   0, 0, 0, 0, 0, 1, OBrRun, OBrRun, 1'b0);
        vec("pc_fl",   0, 0, 0, 0, 0, 0, OFlush, OFlush, 1'b0);
        vec("pc_end",  0, 0, 0, 0, 0, 0, OIdle,  OIdle,  1'b0);
        check_eq("pc_stall5", a_stall_cnt, 16'd5);
        check_eq("pc_flush2", a_flush_cnt, 16'd2);
        drive(8, 0, 0, 1, 8, 0);
        repeat (70000) @(posedge clk);
        #1;
        check_eq("pc_sat", a_stall_cnt, 16'hFFFF);
        check_eq("pc_sat_f", a_flush_cnt, 16'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
